// File: rtl/ad_pkg.sv
// Shared defaults and FSM encoding for the ADC frame reader.
package ad_pkg;

  localparam int AD_CH_NUM = 8;
  localparam int AD_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ad_ch_avg.sv
// Per-channel accumulate-and-dump averager over 2^AVG_LOG2 frames.
// One cycle from sample to average; no backpressure, a result is produced on every final-frame sample.
module ad_ch_avg #(
  parameter int CH_NUM   = 8,
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              smp_valid,
  input  logic [2:0]        smp_ch,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              frame_done,
  output logic [DATA_W-1:0] avg_data,
  output logic [2:0]        avg_ch,
  output logic              avg_valid
);

  localparam int AW = DATA_W + AVG_LOG2;

  logic signed [AW-1:0] acc [CH_NUM];
  logic signed [AW-1:0] sum;
  logic [AVG_LOG2-1:0]  frm_cnt;
  logic                 last_frm;

  assign last_frm = &frm_cnt;
  assign sum      = acc[smp_ch] + {{AVG_LOG2{smp_data[DATA_W-1]}}, smp_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) acc[i] <= '0;
      frm_cnt   <= '0;
      avg_data  <= '0;
      avg_ch    <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= smp_valid && last_frm;
      if (smp_valid) begin
        if (last_frm) begin
          // Dropping the low AVG_LOG2 bits of a signed sum is a floor divide.
          avg_data     <= sum[AW-1:AVG_LOG2];
          avg_ch       <= smp_ch;
          acc[smp_ch]  <= '0;
        end else begin
          acc[smp_ch]  <= sum;
        end
      end
      if (frame_done) frm_cnt <= frm_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ad_frame_reader.sv
// Reads CH_NUM-word ADC frames from a FIFO, tags samples by channel; optional averager under AD_FRAME_AVG_EN.
// Samples appear one cycle after each read strobe; a frame only starts once the FIFO holds a whole frame.
module ad_frame_reader
  import ad_pkg::*;
#(
  parameter int CH_NUM   = AD_CH_NUM,
  parameter int DATA_W   = AD_DATA_W,
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic [5:0]        fifo_usedw,
  output logic              fifo_rdreq,
  output logic [DATA_W-1:0] smp_data,
  output logic [2:0]        smp_ch,
  output logic              smp_valid,
  output logic              frame_done,
  output logic [DATA_W-1:0] avg_data,
  output logic [2:0]        avg_ch,
  output logic              avg_valid
);

  if (CH_NUM < 1 || CH_NUM > 8 || AVG_LOG2 < 1) begin : g_param_err
    $error("ad_frame_reader: CH_NUM must be 1..8 and AVG_LOG2 >= 1");
  end

  state_t            state, state_nxt;
  logic [2:0]        rd_cnt, rd_cnt_nxt;
  logic              rd_vld_q;
  logic [2:0]        rd_ch_q;
  logic [DATA_W-1:0] smp_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rd_cnt   <= '0;
      rd_vld_q <= 1'b0;
      rd_ch_q  <= '0;
      smp_hold <= '0;
    end else begin
      state    <= state_nxt;
      rd_cnt   <= rd_cnt_nxt;
      rd_vld_q <= fifo_rdreq;
      if (fifo_rdreq) rd_ch_q  <= rd_cnt;
      if (rd_vld_q)   smp_hold <= fifo_q;
    end
  end

  // DRAIN plus IDLE give two strobe-free cycles between back-to-back frames.
  always_comb begin
    state_nxt  = state;
    rd_cnt_nxt = rd_cnt;
    fifo_rdreq = 1'b0;
    unique case (state)
      ST_IDLE: begin
        rd_cnt_nxt = '0;
        if (en && int'(fifo_usedw) >= CH_NUM) state_nxt = ST_READ;
      end
      ST_READ: begin
        fifo_rdreq = 1'b1;
        if (rd_cnt == 3'(CH_NUM - 1)) begin
          rd_cnt_nxt = '0;
          state_nxt  = ST_DRAIN;
        end else begin
          rd_cnt_nxt = rd_cnt + 3'd1;
        end
      end
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // fifo_q is live only in the cycle after a strobe; otherwise replay the last sample.
  assign smp_valid  = rd_vld_q;
  assign smp_ch     = rd_ch_q;
  assign smp_data   = rd_vld_q ? fifo_q : smp_hold;
  assign frame_done = rd_vld_q && (rd_ch_q == 3'(CH_NUM - 1));

`ifdef AD_FRAME_AVG_EN
  ad_ch_avg #(
    .CH_NUM   (CH_NUM),
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk        (clk),
    .rst        (rst),
    .smp_valid  (smp_valid),
    .smp_ch     (smp_ch),
    .smp_data   (smp_data),
    .frame_done (frame_done),
    .avg_data   (avg_data),
    .avg_ch     (avg_ch),
    .avg_valid  (avg_valid)
  );
`else
  assign avg_data  = '0;
  assign avg_ch    = '0;
  assign avg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ad_frame_reader.sv
// Directed bench for ad_frame_reader: thresholds, sample timing, en/rst mid-frame, averaging.
module tb_ad_frame_reader;
  import ad_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] fifo_q = '0;
  logic [5:0]  fifo_usedw = '0;
  logic        fifo_rdreq;
  logic [15:0] smp_data;
  logic [2:0]  smp_ch;
  logic        smp_valid;
  logic        frame_done;
  logic [15:0] avg_data;
  logic [2:0]  avg_ch;
  logic        avg_valid;

  logic [15:0] mem [256];
  logic [7:0]  rd_ptr = '0;
  logic        ptr_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  ad_frame_reader dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_q     (fifo_q),
    .fifo_usedw (fifo_usedw),
    .fifo_rdreq (fifo_rdreq),
    .smp_data   (smp_data),
    .smp_ch     (smp_ch),
    .smp_valid  (smp_valid),
    .frame_done (frame_done),
    .avg_data   (avg_data),
    .avg_ch     (avg_ch),
    .avg_valid  (avg_valid)
  );

  always #5 clk = ~clk;

  // Show-ahead-free FIFO: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (ptr_clr) rd_ptr <= '0;
    else if (fifo_rdreq) begin
      fifo_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  task automatic load_seq(input logic [15:0] base);
    for (int i = 0; i < 256; i++) mem[i] = base + 16'(i);
    ptr_clr = 1'b1;
    @(negedge clk);
    ptr_clr = 1'b0;
  endtask

  // Expected {rdreq, smp_valid, frame_done, smp_ch, smp_data} at cycle c when frames start every 10 cycles.
  function automatic logic [21:0] frame_exp(input int c, input int nfr, input logic [15:0] base,
                                            input logic [2:0] ch0, input logic [15:0] d0);
    logic rq, vld, fd;
    logic [2:0] ch;
    logic [15:0] d;
    rq = 1'b0; vld = 1'b0; fd = 1'b0; ch = ch0; d = d0;
    for (int f = 0; f < nfr; f++) begin
      if (c >= 10 * f && c < 10 * f + 8) rq = 1'b1;
      for (int k = 0; k < 8; k++) begin
        if (c >= 10 * f + 1 + k) begin
          ch = 3'(k);
          d  = base + 16'(8 * f + k);
          if (c == 10 * f + 1 + k) begin
            vld = 1'b1;
            fd  = (k == 7);
          end
        end
      end
    end
    return {rq, vld, fd, ch, d};
  endfunction

  task automatic test_reset;
    logic [43:0] obs;
    rst = 1'b1; en = 1'b0; fifo_usedw = 6'd0;
    repeat (2) @(negedge clk);
    obs = {fifo_rdreq, smp_valid, frame_done, avg_valid, smp_data, smp_ch, avg_data, avg_ch};
    n_cmp++;
    if (obs !== 44'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame;
    logic [21:0] obs, exp;
    load_seq(16'h0000);
    en = 1'b1; fifo_usedw = 6'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (fifo_rdreq !== 1'b0) begin
        n_err++;
        $display("FAIL usedw7_no_rdreq c=%0d: got %b expected 0", c, fifo_rdreq);
      end
    end
    fifo_usedw = 6'd8;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) fifo_usedw = 6'd0;
      obs = {fifo_rdreq, smp_valid, frame_done, smp_ch, smp_data};
      exp = frame_exp(c, 1, 16'h0000, 3'd0, 16'h0000);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL frame c=%0d: got %h expected %h", c, obs, exp);
      end
    end
  endtask

  task automatic test_en_drop;
    logic [21:0] obs, exp;
    load_seq(16'h0010);
    en = 1'b1; fifo_usedw = 6'd8;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 3) en = 1'b0;
      obs = {fifo_rdreq, smp_valid, frame_done, smp_ch, smp_data};
      exp = frame_exp(c, 1, 16'h0010, 3'd7, 16'h0007);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL en_drop c=%0d: got %h expected %h", c, obs, exp);
      end
    end
    fifo_usedw = 6'd0;
  endtask

  task automatic test_back_to_back;
    logic [21:0] obs, exp;
    load_seq(16'h0020);
    en = 1'b1; fifo_usedw = 6'd8;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (c == 10) en = 1'b0;
      obs = {fifo_rdreq, smp_valid, frame_done, smp_ch, smp_data};
      exp = frame_exp(c, 2, 16'h0020, 3'd7, 16'h0017);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL back_to_back c=%0d: got %h expected %h", c, obs, exp);
      end
    end
    fifo_usedw = 6'd0;
  endtask

  task automatic test_reset_mid;
    logic [43:0] obs;
    load_seq(16'h0030);
    en = 1'b1; fifo_usedw = 6'd8;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 4) rst = 1'b1;
    end
    obs = {fifo_rdreq, smp_valid, frame_done, avg_valid, smp_data, smp_ch, avg_data, avg_ch};
    n_cmp++;
    if (obs !== 44'd0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %h expected 0", obs);
    end
    n_cmp++;
    if (dut.state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_mid_state: got %0d expected %0d", dut.state, ST_IDLE);
    end
    rst = 1'b0; fifo_usedw = 6'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (fifo_rdreq !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_idle c=%0d: got %b expected 0", c, fifo_rdreq);
      end
    end
  endtask

  task automatic test_avg;
    logic [19:0] obs, exp;
    logic        e_av;
    logic [2:0]  e_ch;
    logic [15:0] e_d;
    rst = 1'b1; en = 1'b0; fifo_usedw = 6'd0;
    for (int f = 0; f < 16; f++)
      for (int k = 0; k < 8; k++)
        mem[8 * f + k] = (k == 0) ? 16'hFFFD : (k == 1) ? ((f % 2 == 1) ? 16'd2 : 16'd1) : 16'(4 * k);
    ptr_clr = 1'b1;
    repeat (2) @(negedge clk);
    ptr_clr = 1'b0; rst = 1'b0;
    en = 1'b1; fifo_usedw = 6'd8;
    e_ch = '0; e_d = '0;
    for (int c = 0; c < 170; c++) begin
      @(negedge clk);
      if (c == 150) en = 1'b0;
      e_av = 1'b0;
`ifdef AD_FRAME_AVG_EN
      if (c >= 152 && c <= 159) begin
        e_av = 1'b1;
        e_ch = 3'(c - 152);
        e_d  = (c == 152) ? 16'hFFFD : (c == 153) ? 16'd1 : 16'(4 * (c - 152));
      end
`endif
      obs = {avg_valid, avg_ch, avg_data};
      exp = {e_av, e_ch, e_d};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL avg c=%0d: got %h expected %h", c, obs, exp);
      end
    end
    fifo_usedw = 6'd0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_en_drop();
    test_back_to_back();
    test_reset_mid();
    test_avg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
